mem_access_master: RTL and testbench
====================================

Name: mem_access_master

Overview:
- Initiator side of the instruction/data memory port: accepts 16-bit word read and write requests from the multi-cycle CPU datapath.
- Sequences them onto the memory's byte-write / word-read interface.
- Memory read is combinational {M[a+1],M[a]} (little-endian). Memory write is one byte per rising clk edge when the write enable is high, so a 16-bit store takes two write cycles.
- Sits between the control unit / datapath and the memory; gives the CPU a simple valid/ready request and a one-cycle response pulse.

Parameters:
- ADDR_W, 8, byte-address width of memory port and request address.
- MEM_BYTES, 64, number of implemented memory bytes; used for range checking.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_write  input  1  1 = 16-bit store, 0 = 16-bit load
- req_addr  input  ADDR_W  byte address of low byte
- req_wdata  input  16  store data, [7:0] to addr, [15:8] to addr+1
- req_ready  output  1  block can accept a request this cycle
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  16  load data, valid while rsp_valid, held afterwards
- rsp_err  output  1  request rejected, valid with rsp_valid
- mem_addr  output  ADDR_W  memory byte address
- mem_wd  output  8  memory write byte
- mem_we  output  1  memory write enable
- mem_rd  input  16  memory read word {M[mem_addr+1],M[mem_addr]}

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1, rsp_valid=0, rsp_err=0.
  - rsp_rdata=0, mem_addr=0, mem_wd=0, mem_we=0.
- All outputs are registered; mem_we never glitches.
- FSM states: IDLE, RD, WR_LO, WR_HI, RESP.
- IDLE:
  - req_ready=1, mem_we=0.
  - On req_valid=1, latch addr, wdata and write, and set req_ready=0.
  - Range fail (latched addr > MEM_BYTES-2) -> RESP with err=1. No mem_we, rsp_rdata unchanged.
  - Otherwise read -> RD, write -> WR_LO.
- RD:
  - mem_addr=addr, mem_we=0.
  - Capture mem_rd into rsp_rdata at the end of this cycle -> RESP.
- WR_LO: mem_addr=addr, mem_wd=wdata[7:0], mem_we=1 -> WR_HI.
- WR_HI: mem_addr=addr+1 (computed in ADDR_W bits), mem_wd=wdata[15:8], mem_we=1 -> RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err as determined; mem_we=0.
  - A write leaves rsp_rdata unchanged.
  - Next state IDLE, with req_ready=1 from the next cycle.
- Latency, with accept at edge N:
  - Read: rsp_valid high in cycle N+2.
  - Write: the two bytes are written at edges N+1 and N+2; rsp_valid high in cycle N+3.
  - Error: rsp_valid high in cycle N+1.
- There is no response back-pressure; the consumer must sample rsp_valid.
- req_valid while req_ready=0 is ignored, not queued. The requester must hold the request until it sees req_ready=1.
- Back-to-back: a new request can be accepted in the first IDLE cycle after RESP.
- Reset mid-operation aborts immediately: mem_we drops asynchronously. A store aborted after WR_LO leaves only the low byte written; this partial write is architecturally accepted.
- mem_addr and mem_wd hold their last values in IDLE and RESP.

Optional Feature:
- Macro ALIGN_CHECK_EN.
- Defined: a request with req_addr[0]=1 also fails the check. It goes to RESP with rsp_err=1, no memory access, and rsp_rdata unchanged.
- Undefined: odd addresses are legal. Loads return {M[a+1],M[a]}; stores write a then a+1. Only the range check applies.

Test Plan:
- Store 0xBEEF at 0x10:
  - mem_we=1 for two cycles: addr 0x10 with wd 0xEF, then addr 0x11 with wd 0xBE.
  - rsp_valid at N+3 with rsp_err=0.
  - Then load 0x10 -> rsp_rdata=0xBEEF at N+2.
- Load 0x00 from the preloaded image -> rsp_rdata equals the 16-bit word at bytes 1:0, rsp_valid exactly one cycle.
- Store and load at 0x3F (63) with MEM_BYTES=64:
  - rsp_err=1 at N+1.
  - mem_we never asserted.
  - rsp_rdata keeps its prior value.
  - Load at 0x3E succeeds.
- Drive req_valid continuously with changing addresses during a store -> only the first is accepted. The next is accepted on the first cycle req_ready=1 after RESP; no extra mem_we pulses.
- Pull rst_n low during WR_HI -> mem_we, rsp_valid and req_ready go to reset values without waiting for clk. Only the low byte has changed in memory; the FSM restarts in IDLE.
- Load at 0x05:
  - With ALIGN_CHECK_EN -> rsp_err=1, no access.
  - Without -> rsp_rdata={M[6],M[5]}, rsp_err=0.

Source files
------------

// File: rtl/mem_access_master.sv
// 16-bit load/store sequencer onto a byte-write / word-read memory port.
// Define ALIGN_CHECK_EN to also reject odd (unaligned) request addresses.
module mem_access_master #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wd,
    output logic              mem_we,
    input  logic [15:0]       mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_LO,
        WR_HI,
        RESP
    } state_t;

    localparam int unsigned LAST_OK = MEM_BYTES - 2;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata_hi;

    logic w_range_err;
    logic w_align_err;
    logic w_req_err;

    // The word occupies bytes a and a+1, so the last legal low-byte address is MEM_BYTES-2.
    assign w_range_err = 32'(req_addr) > LAST_OK;
`ifdef ALIGN_CHECK_EN
    assign w_align_err = req_addr[0];
`else
    assign w_align_err = 1'b0;
`endif
    assign w_req_err = w_range_err | w_align_err;

    // Memory-side outputs are loaded on the accepting edge so they are valid
    // throughout the first access cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_wdata_hi <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            mem_we     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        r_addr     <= req_addr;
                        r_wdata_hi <= req_wdata[15:8];
                        if (w_req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            r_state   <= RESP;
                        end else if (req_write) begin
                            mem_addr <= req_addr;
                            mem_wd   <= req_wdata[7:0];
                            mem_we   <= 1'b1;
                            r_state  <= WR_LO;
                        end else begin
                            mem_addr <= req_addr;
                            r_state  <= RD;
                        end
                    end
                end
                RD: begin
                    rsp_rdata <= mem_rd;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    r_state   <= RESP;
                end
                WR_LO: begin
                    mem_addr <= r_addr + ADDR_W'(1);
                    mem_wd   <= r_wdata_hi;
                    r_state  <= WR_HI;
                end
                WR_HI: begin
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    r_state   <= RESP;
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    mem_we    <= 1'b0;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_master.sv
// Randomized self-checking bench for mem_access_master against a byte-array reference model.
module tb_mem_access_master;

    localparam int unsigned AW = 8;
    localparam int unsigned NB = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [15:0]   req_wdata = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic [15:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wd;
    logic          mem_we;
    logic [15:0]   mem_rd;

    mem_access_master #(.ADDR_W(AW), .MEM_BYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] last_rdata;
    logic [7:0]  w_nxt;
    int          total = 0;
    int          bad = 0;

    assign w_nxt  = mem_addr + 8'd1;
    assign mem_rd = {mem[w_nxt], mem[mem_addr]};

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [7:0] a);
        logic e;
        e = int'(a) > int'(NB) - 2;
`ifdef ALIGN_CHECK_EN
        e = e | a[0];
`endif
        return e;
    endfunction

    // Called just after a negedge while the DUT is idle.
    task automatic do_req(input logic w, input logic [7:0] a, input logic [15:0] d, input bit junk);
        logic        err;
        int          exp_lat, exp_nev, lat, guard, nev;
        logic [7:0]  ev_a [4];
        logic [7:0]  ev_d [4];
        logic [7:0]  a1;
        logic [15:0] exp_rd, got_rd;
        logic        got_err;
        err     = model_err(a);
        exp_lat = err ? 1 : (w ? 3 : 2);
        exp_nev = (w && !err) ? 2 : 0;
        a1      = a + 8'd1;
        exp_rd  = (!err && !w) ? {ref_mem[a1], ref_mem[a]} : last_rdata;
        got_rd  = 'x;
        got_err = 1'bx;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        guard = 0;
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", guard, 0);
        @(posedge clk);
        lat = 0;
        nev = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_ready", req_ready, 0);
            if (mem_we) begin
                if (nev < 4) begin
                    ev_a[nev] = mem_addr;
                    ev_d[nev] = mem_wd;
                end
                nev++;
            end
            if (rsp_valid) begin
                lat     = k;
                got_rd  = rsp_rdata;
                got_err = rsp_err;
                break;
            end
            if (junk) begin
                req_valid = 1'b1;
                req_write = 1'($urandom);
                req_addr  = 8'($urandom_range(0, 62));
                req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0;
                req_addr  = 8'($urandom);
                req_wdata = 16'($urandom);
            end
        end
        req_valid = 1'b0;
        chk("latency", lat, exp_lat);
        chk("rsp_err", got_err, err);
        chk("rsp_rdata", got_rd, exp_rd);
        chk("we_count", nev, exp_nev);
        for (int i = 0; i < exp_nev && i < nev; i++) begin
            chk("we_addr", ev_a[i], (i == 0) ? a : a1);
            chk("we_data", ev_d[i], (i == 0) ? d[7:0] : d[15:8]);
        end
        @(negedge clk);
        chk("pulse_end", rsp_valid, 0);
        chk("ready_back", req_ready, 1);
        chk("rdata_hold", rsp_rdata, exp_rd);
        chk("idle_we", mem_we, 0);
        if (w && !err) begin
            ref_mem[a]  = d[7:0];
            ref_mem[a1] = d[15:8];
        end
        last_rdata = exp_rd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = (i < int'(NB)) ? 8'($urandom) : 8'h00;
            ref_mem[i] = mem[i];
        end
        last_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_mem_we", mem_we, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b1, 8'h10, 16'hBEEF, 1'b0);
        do_req(1'b0, 8'h10, 16'h0000, 1'b0);
        chk("beef_load", rsp_rdata, 16'hBEEF);
        do_req(1'b0, 8'h00, 16'h0000, 1'b0);
        do_req(1'b1, 8'h3F, 16'h5A5A, 1'b0);
        do_req(1'b0, 8'h3F, 16'h0000, 1'b0);
        do_req(1'b0, 8'h3E, 16'h0000, 1'b0);
        do_req(1'b1, 8'h20, 16'hC3A5, 1'b1);
        do_req(1'b0, 8'h20, 16'h0000, 1'b0);
        do_req(1'b0, 8'h05, 16'h0000, 1'b0);

        // Reset asserted in the second write cycle.
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h24; req_wdata = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wrhi_we", mem_we, 1);
        chk("wrhi_addr", mem_addr, 8'h25);
        rst_n = 1'b0;
        #1;
        chk("arst_we", mem_we, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_ready", req_ready, 1);
        chk("arst_rdata", rsp_rdata, 0);
        ref_mem[8'h24] = 8'h34;
        last_rdata = '0;
        chk("partial_lo", mem[8'h24], 8'h34);
        chk("partial_hi", mem[8'h25], ref_mem[8'h25]);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_req(1'b0, 8'h24, 16'h0000, 1'b0);

        repeat (40) begin
            do_req(1'($urandom_range(0, 1)), 8'($urandom_range(0, 68)), 16'($urandom),
                   $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < int'(NB); i++) chk("image", mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
